mux_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer. It generalises the combinational 4:1 select used in the lab datapaths. Two modes are supported: manual select from a sel input, and an autonomous scan mode that steps through the channels with a programmable dwell time. It feeds shared downstream consumers (display/serial/LED paths) that must time-share one bus among several sources.

---
 rtl/mux_scan.sv | 117 +++++++++++
 tb/tb_mux_scan.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer with manual select and an autonomous
// scan mode that dwells DWELL enabled cycles on each channel before advancing.
module mux_scan #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  din,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            hold,
    input  logic            en,
    output logic [W-1:0]    y,
    output logic            y_valid,
    output logic [SELW-1:0] cur_sel,
    output logic            wrap
);
    localparam int              CNTW     = $clog2(DWELL + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(N - 1);

    typedef enum logic [0:0] {
        ST_MAN  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CNTW-1:0] cnt_r;
    logic [CNTW-1:0] cnt_base_s;
    logic [CNTW-1:0] cnt_nxt_s;
    logic [SELW-1:0] nxt_s;
    logic            wrap_nxt_s;
    logic [W-1:0]    y_nxt_s;
    logic            valid_nxt_s;
    logic [W-1:0]    y_r;
    logic            y_valid_r;
    logic [SELW-1:0] cur_sel_r;
    logic            wrap_r;

    // Next-index, dwell counter and wrap decision for the coming enabled edge.
    always_comb begin
        state_nxt_s = ST_MAN;
        cnt_base_s  = '0;
        cnt_nxt_s   = '0;
        nxt_s       = sel;
        wrap_nxt_s  = 1'b0;
        if (mode) begin
            state_nxt_s = ST_SCAN;
            // Entering scan from manual always starts a fresh dwell period.
            cnt_base_s  = (state_r == ST_SCAN) ? cnt_r : '0;
            if (hold) begin
                nxt_s     = cur_sel_r;
                cnt_nxt_s = cnt_base_s;
            end else if (cnt_base_s != CNT_LAST) begin
                nxt_s     = cur_sel_r;
                cnt_nxt_s = cnt_base_s + CNTW'(1);
            end else begin
                cnt_nxt_s = '0;
                // An out-of-range pointer re-enters at channel 0 without a wrap pulse.
                if (cur_sel_r == SEL_LAST) begin
                    nxt_s      = '0;
                    wrap_nxt_s = 1'b1;
                end else if (cur_sel_r > SEL_LAST) begin
                    nxt_s      = '0;
                    wrap_nxt_s = 1'b0;
                end else begin
                    nxt_s      = cur_sel_r + SELW'(1);
                    wrap_nxt_s = 1'b0;
                end
            end
        end else begin
            state_nxt_s = ST_MAN;
            nxt_s       = sel;
        end
    end

    // Channel data selected by nxt_s; zero and invalid when nxt_s is out of range.
    always_comb begin
        y_nxt_s     = '0;
        valid_nxt_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            y_nxt_s     = y_nxt_s | ({W{nxt_s == SELW'(k)}} & din[k*W +: W]);
            valid_nxt_s = valid_nxt_s | (nxt_s == SELW'(k));
        end
    end

    // State, counter and output registers; en gates every update, wrap clears when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_MAN;
            cnt_r     <= '0;
            y_r       <= '0;
            y_valid_r <= 1'b0;
            cur_sel_r <= '0;
            wrap_r    <= 1'b0;
        end else if (en) begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            y_r       <= y_nxt_s;
            y_valid_r <= valid_nxt_s;
            cur_sel_r <= nxt_s;
            wrap_r    <= wrap_nxt_s;
        end else begin
            wrap_r    <= 1'b0;
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign cur_sel = cur_sel_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_mux_scan.sv
// Randomised bench for mux_scan: a 4-channel and a 3-channel instance are run
// against a behavioural model, with directed sequences pinned to literal values.
module tb_mux_scan;
    localparam int DW = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        hold;
    logic        mode_a;
    logic        mode_b;
    logic [31:0] din_a;
    logic [23:0] din_b;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [7:0]  y_a;
    logic [7:0]  y_b;
    logic        yv_a;
    logic        yv_b;
    logic [1:0]  cs_a;
    logic [1:0]  cs_b;
    logic        wrap_a;
    logic        wrap_b;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        int         ptr;
        int         dwell;
        logic [7:0] y;
        logic       v;
        logic       wrap;
    } mstate_t;

    mstate_t ma;
    mstate_t mb;

    mux_scan #(.N(4), .W(8), .DWELL(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .sel(sel_a), .mode(mode_a),
        .hold(hold), .en(en), .y(y_a), .y_valid(yv_a), .cur_sel(cs_a), .wrap(wrap_a)
    );

    mux_scan #(.N(3), .W(8), .DWELL(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .sel(sel_b), .mode(mode_b),
        .hold(hold), .en(en), .y(y_b), .y_valid(yv_b), .cur_sel(cs_b), .wrap(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pointer plus count of finished dwell cycles on the current channel.
    function automatic mstate_t mstep(mstate_t s, int n, logic [31:0] d, int sel,
                                      bit mode, bit hld, bit ena);
        mstate_t r;
        r = s;
        r.wrap = 1'b0;
        if (!ena) return r;
        if (!mode) begin
            r.ptr   = sel;
            r.dwell = 0;
        end else if (!hld) begin
            r.dwell = r.dwell + 1;
            if (r.dwell == DW) begin
                r.dwell = 0;
                r.wrap  = (r.ptr == n - 1);
                r.ptr   = (r.ptr >= n - 1) ? 0 : r.ptr + 1;
            end
        end
        r.v = (r.ptr < n);
        r.y = r.v ? 8'((d >> (8 * r.ptr)) & 32'hFF) : 8'h00;
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a.y", int'(y_a), int'(ma.y));
        chk("a.y_valid", int'(yv_a), int'(ma.v));
        chk("a.cur_sel", int'(cs_a), ma.ptr);
        chk("a.wrap", int'(wrap_a), int'(ma.wrap));
        chk("b.y", int'(y_b), int'(mb.y));
        chk("b.y_valid", int'(yv_b), int'(mb.v));
        chk("b.cur_sel", int'(cs_b), mb.ptr);
        chk("b.wrap", int'(wrap_b), int'(mb.wrap));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            ma = '0;
            mb = '0;
        end else begin
            ma = mstep(ma, 4, din_a, int'(sel_a), mode_a, hold, en);
            mb = mstep(mb, 3, {8'h00, din_b}, int'(sel_b), mode_b, hold, en);
        end
        @(negedge clk);
        compare_all();
    endtask

    // Pulse reset between edges and check outputs clear without a clock edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        ma = '0;
        mb = '0;
        compare_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        hold   = 1'b0;
        mode_a = 1'b0;
        mode_b = 1'b0;
        sel_a  = 2'd0;
        sel_b  = 2'd0;
        din_a  = 32'h44332211;
        din_b  = 24'h332211;
        ma     = '0;
        mb     = '0;
        @(negedge clk);
        step();
        chk("rst.y", int'(y_a), 0);
        chk("rst.valid", int'(yv_a), 0);

        // Scan sequence from reset.
        rst_n  = 1'b1;
        mode_a = 1'b1;
        begin
            logic [7:0] exp_seq [9] = '{8'h11, 8'h22, 8'h22, 8'h33, 8'h33,
                                        8'h44, 8'h44, 8'h11, 8'h11};
            for (int i = 0; i < 9; i++) begin
                step();
                chk("scan.y", int'(y_a), int'(exp_seq[i]));
                chk("scan.wrap", int'(wrap_a), (i == 7) ? 1 : 0);
            end
        end

        // Asynchronous reset mid-scan, then restart from channel 0.
        step();
        step();
        async_reset();
        chk("arst.y", int'(y_a), 0);
        chk("arst.cur_sel", int'(cs_a), 0);
        step();
        chk("arst.first", int'(y_a), 32'h11);

        // Manual select.
        mode_a = 1'b0;
        sel_a  = 2'd2;
        step();
        chk("man.y2", int'(y_a), 32'h33);
        chk("man.cs2", int'(cs_a), 2);
        chk("man.v2", int'(yv_a), 1);
        sel_a = 2'd0;
        step();
        chk("man.y0", int'(y_a), 32'h11);
        din_a[7:0] = 8'h5A;
        step();
        chk("man.track", int'(y_a), 32'h5A);
        din_a = 32'h44332211;

        // Hold and enable.
        mode_a = 1'b1;
        step();
        step();
        chk("hold.start", int'(cs_a), 1);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold.cs", int'(cs_a), 1);
        end
        din_a[15:8] = 8'h99;
        step();
        chk("hold.track", int'(y_a), 32'h99);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_a = $urandom;
            step();
            chk("en0.y", int'(y_a), 32'h99);
            chk("en0.cs", int'(cs_a), 1);
            chk("en0.wrap", int'(wrap_a), 0);
        end
        en    = 1'b1;
        hold  = 1'b0;
        din_a = 32'h44332211;

        // Mode switch manual -> scan -> manual.
        mode_a = 1'b0;
        sel_a  = 2'd3;
        step();
        chk("ms.man3", int'(y_a), 32'h44);
        mode_a = 1'b1;
        step();
        chk("ms.dwell", int'(y_a), 32'h44);
        chk("ms.nowrap", int'(wrap_a), 0);
        step();
        chk("ms.adv", int'(y_a), 32'h11);
        chk("ms.wrap", int'(wrap_a), 1);
        mode_a = 1'b0;
        sel_a  = 2'd1;
        step();
        chk("ms.back", int'(y_a), 32'h22);

        // Out-of-range select on the 3-channel instance.
        mode_b = 1'b0;
        sel_b  = 2'd3;
        step();
        chk("oor.y", int'(y_b), 0);
        chk("oor.v", int'(yv_b), 0);
        chk("oor.cs", int'(cs_b), 3);
        mode_b = 1'b1;
        step();
        step();
        chk("oor.resume.y", int'(y_b), 32'h11);
        chk("oor.resume.v", int'(yv_b), 1);
        chk("oor.resume.wrap", int'(wrap_b), 0);

        // Randomised phase.
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            hold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 15) == 0) mode_b = ~mode_b;
            sel_a = 2'($urandom);
            sel_b = 2'($urandom);
            din_a = $urandom;
            din_b = 24'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
